// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller state type and the iteration count.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage request/response bundle between the pipeline controller
// (master) and the multiply/divide unit (slave).
interface mult_div_unit_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [1:0]       hilo_we;
  logic [WIDTH-1:0] wdata;
  logic             hilo_sel;
  logic             run;
  logic [WIDTH-1:0] hilo_out;

  modport master (
    output start, op, srca, srcb, hilo_we, wdata, hilo_sel,
    input  run, hilo_out
  );

  modport slave (
    input  start, op, srca, srcb, hilo_we, wdata, hilo_sel,
    output run, hilo_out
  );

endinterface

// File: rtl/md_sign_fix.sv
// Final sign correction of the unsigned iteration result into architectural
// hi/lo values, including the divide-by-zero result.
module md_sign_fix
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  input  md_op_e           op,
  input  logic             res_neg,
  input  logic             rem_neg,
  input  logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] neg_prod;
  logic [WIDTH-1:0]   neg_quo;
  logic [WIDTH-1:0]   neg_rem;

  assign neg_prod = -{raw_hi, raw_lo};
  assign neg_quo  = -raw_lo;
  assign neg_rem  = -raw_hi;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hi = raw_hi;
    lo = raw_lo;
    case (op)
      MD_MULT: begin
        if (res_neg) {hi, lo} = neg_prod;
      end
      MD_MULTU: ;
      MD_DIV: begin
        // With a zero divisor the raw remainder is |dividend|, so the normal
        // remainder sign fix restores the original dividend.
        lo = div_zero ? '1 : (res_neg ? neg_quo : raw_lo);
        hi = rem_neg ? neg_rem : raw_hi;
      end
      MD_DIVU: begin
        lo = div_zero ? '1 : raw_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32 radix-2 steps (shift-add or
// restoring division) followed by one sign-fix cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  md_state_e        state;
  logic             run_q;
  logic [CW-1:0]    cnt;
  md_op_e           op_q;
  logic             res_neg;
  logic             rem_neg;
  logic             div_zero;
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / quotient bits
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             is_signed;
  logic             is_mul;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign is_signed = ~bus.op[0];
  assign is_mul    = ~bus.op[1];
  assign a_abs     = (is_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign b_abs     = (is_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

  // A shifted partial remainder is always below twice the divisor, so the
  // trial difference's top bit is exactly the "did not fit" indication.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (!op_q[1]) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      nxt_hi = div_trial[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw_hi   (acc_hi),
    .raw_lo   (acc_lo),
    .op       (op_q),
    .res_neg  (res_neg),
    .rem_neg  (rem_neg),
    .div_zero (div_zero),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. The datapath
  // registers are reset too, keeping a mid-operation reset fully clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      run_q    <= 1'b0;
      cnt      <= '0;
      op_q     <= MD_MULT;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CALC;
            run_q    <= 1'b1;
            cnt      <= '0;
            op_q     <= bus.op;
            res_neg  <= is_signed && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            rem_neg  <= is_signed && bus.srca[WIDTH-1];
            div_zero <= (bus.srcb == '0);
            opnd     <= is_mul ? a_abs : b_abs;
            acc_hi   <= '0;
            acc_lo   <= is_mul ? b_abs : a_abs;
          end else begin
            if (bus.hilo_we[1]) hi <= bus.wdata;
            if (bus.hilo_we[0]) lo <= bus.wdata;
          end
        end
        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          run_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run      = run_q;
  assign bus.hilo_out = bus.hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model with a
// per-cycle compare process, literal directed cases and randomized traffic.
module tb_mult_div_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the instruction semantics.
  function automatic void ref_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      MD_MULTU: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      MD_DIV: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
      end
      MD_DIVU: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Model: busy countdown of 33 edges after an accepted start, result lands
  // when it expires; writes only while not busy and not starting.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_busy = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (bus.start) begin
      ref_op(bus.op, bus.srca, bus.srcb, p_hi, p_lo);
      m_busy = 33;
    end else begin
      if (bus.hilo_we[1]) m_hi = bus.wdata;
      if (bus.hilo_we[0]) m_lo = bus.wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("run", {63'b0, bus.run}, {63'b0, (m_busy > 0)});
      check("hilo_out", {32'b0, bus.hilo_out}, {32'b0, (bus.hilo_sel ? m_hi : m_lo)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    bus.hilo_sel = 1'b1; #1;
    check({name, " hi"}, {32'b0, bus.hilo_out}, {32'b0, ehi});
    bus.hilo_sel = 1'b0; #1;
    check({name, " lo"}, {32'b0, bus.hilo_out}, {32'b0, elo});
  endtask

  // Issue one op, scramble inputs afterwards, count cycles with run high.
  task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b, output int n);
    bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
    cyc();
    bus.start = 1'b0; bus.hilo_we = 2'b00;
    bus.op = md_op_e'($urandom_range(0, 3)); bus.srca = $urandom; bus.srcb = $urandom;
    n = 0;
    while (bus.run && n < 40) begin n++; cyc(); end
    check("op completes", {63'b0, bus.run}, 64'd0);
  endtask

  task automatic lit(input string name, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    do_op(op, a, b, n);
    check({name, " busy cycles"}, 64'(n), 64'd33);
    read_hilo(name, ehi, elo);
  endtask

  initial begin
    int n, k;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = MD_MULT; bus.srca = '0; bus.srcb = '0;
    bus.hilo_we = 2'b00; bus.wdata = '0; bus.hilo_sel = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset run", {63'b0, bus.run}, 64'd0);
    read_hilo("reset", 32'h0, 32'h0);

    lit("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    lit("mult -3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    lit("mult min^2", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    lit("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    lit("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    lit("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    lit("div -9/0", MD_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    lit("div 5/0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // MTHI while idle; lo keeps the divide-by-zero result.
    bus.hilo_we = 2'b10; bus.wdata = 32'h1234;
    cyc();
    bus.hilo_we = 2'b00;
    read_hilo("mthi idle", 32'h1234, 32'hFFFF_FFFF);

    // Mid-operation MTHI and a second start are both ignored.
    bus.start = 1'b1; bus.op = MD_MULTU; bus.srca = 32'd3; bus.srcb = 32'd5;
    cyc();
    bus.start = 1'b0;
    n = 0;
    for (k = 1; k <= 40 && bus.run; k++) begin
      n++;
      bus.hilo_we = (k == 5) ? 2'b10 : 2'b00;
      bus.wdata   = 32'h1234;
      bus.start   = (k == 10);
      bus.op      = MD_DIVU;
      cyc();
    end
    bus.start = 1'b0; bus.hilo_we = 2'b00;
    check("ignored start busy cycles", 64'(n), 64'd33);
    read_hilo("ignored writes", 32'd0, 32'd15);

    // Reset at cycle 20 aborts and discards the in-flight result.
    bus.start = 1'b1; bus.op = MD_MULT; bus.srca = 32'hFFFF_FFFF; bus.srcb = 32'd9;
    cyc();
    bus.start = 1'b0;
    repeat (19) cyc();
    check("run before abort", {63'b0, bus.run}, 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("run after abort", {63'b0, bus.run}, 64'd0);
    read_hilo("abort", 32'h0, 32'h0);
    repeat (40) cyc();
    read_hilo("no late writeback", 32'h0, 32'h0);

    // Randomized traffic, including start colliding with a write.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(1, 3)) begin
        bus.hilo_we = 2'($urandom_range(0, 3)); bus.wdata = $urandom;
        bus.hilo_sel = 1'($urandom_range(0, 1));
        cyc();
      end
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'h0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      bus.hilo_we = 2'($urandom_range(0, 3)); bus.wdata = $urandom;
      bus.hilo_sel = 1'($urandom_range(0, 1));
      do_op(md_op_e'($urandom_range(0, 3)), a, b, n);
      check("random busy cycles", 64'(n), 64'd33);
    end
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
